// File: rtl/cpu_defs.sv
// Shared definitions for the memory-access stage: size codes, writeback
// control bit positions, FSM state encoding and the mem-to-wb bundle.
package cpu_defs;

  // access size encoding on e_size / data_size
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // bit positions inside the writeback control vector
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_LINK     = 2;
  localparam int CTRL_MFC0     = 3;
  localparam int CTRL_HI_WEN   = 4;
  localparam int CTRL_LO_WEN   = 5;
  localparam int CTRL_CP0_WEN  = 6;
  localparam int CTRL_SPARE    = 7;
  localparam int CTRL_W_DEF    = 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} mem_state_t;

  // what the WB register captures this cycle
  typedef enum logic [1:0] {WB_BUBBLE, WB_PASS, WB_HOLD} wb_sel_t;

  // memory instruction parked while its bus transaction is in flight
  typedef struct packed {
    logic        memread;
    logic        memwrite;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] ex_out;
    logic [31:0] wdata;
    logic [31:0] pcplus8;
    logic [4:0]  reg_waddr;
    logic [31:0] cp0_rdata;
  } mem_hold_t;

  // mem-to-wb fields, for wrappers that want a single packed bundle
  typedef struct packed {
    logic                  valid;
    logic [31:0]           ex_out;
    logic [31:0]           rdata_out;
    logic [31:0]           pcplus8;
    logic [4:0]            reg_waddr;
    logic [31:0]           cp0_rdata;
    logic [CTRL_W_DEF-1:0] ctrl;
  } dp_mtow;

  // replicate right-aligned store data across every byte lane of the size
  function automatic logic [31:0] lane_rep(input logic [1:0] size, input logic [31:0] d);
    case (size)
      SZ_BYTE: return {4{d[7:0]}};
      SZ_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_rdata_ext.sv
// Load data extraction: pick the addressed byte/half out of the bus word
// and sign- or zero-extend it to 32 bits.
module mem_rdata_ext
  import cpu_defs::*;
(
  input  logic        sign,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] out
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // lane select then extension
  always_comb begin
    byte_v = rdata[{offset, 3'b000} +: 8];
    half_v = offset[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: out = {{24{sign & byte_v[7]}}, byte_v};
      SZ_HALF: out = {{16{sign & half_v[15]}}, half_v};
      default: out = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: runs the two-phase data bus handshake for loads and
// stores, stalls execute while a transaction is open, and registers the
// fields consumed by writeback.
module mem_stage
  import cpu_defs::*;
#(
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              e_valid,
  input  logic              e_memread,
  input  logic              e_memwrite,
  input  logic [1:0]        e_size,
  input  logic              e_sign,
  input  logic [31:0]       e_ex_out,
  input  logic [31:0]       e_wdata,
  input  logic [31:0]       e_pcplus8,
  input  logic [4:0]        e_reg_waddr,
  input  logic [31:0]       e_cp0_rdata,
  input  logic [CTRL_W-1:0] e_ctrl,
  input  logic              flush,
  output logic              m_stall,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [31:0]       data_addr,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  output logic              w_valid,
  output logic [31:0]       w_ex_out,
  output logic [31:0]       w_rdata_out,
  output logic [31:0]       w_pcplus8,
  output logic [4:0]        w_reg_waddr,
  output logic [31:0]       w_cp0_rdata,
  output logic [CTRL_W-1:0] w_ctrl
);

  mem_state_t  state, nxt;
  wb_sel_t     wb_sel;
  mem_hold_t   hold;
  logic [CTRL_W-1:0] hold_ctrl;
  logic        memop, latch_hold;
  logic [31:0] ext_data;

  assign memop = e_memread | e_memwrite;

  // bus request fields always come from the parked instruction
  assign data_wr    = hold.memwrite;
  assign data_size  = hold.size;
  assign data_addr  = hold.ex_out;
  assign data_wdata = lane_rep(hold.size, hold.wdata);

  mem_rdata_ext u_ext (
    .sign   (hold.sign),
    .size   (hold.size),
    .offset (hold.ex_out[1:0]),
    .rdata  (data_rdata),
    .out    (ext_data)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // next state, stall, bus request and WB source selection.
  // While REQ/WAIT stall, execute keeps presenting the parked instruction,
  // so e_* is ignored there. A flushed transaction already accepted by the
  // bus must still see its data_ok (DRAIN); non-memory instructions refilling
  // behind the flush flow straight through since they are not stalled.
  always_comb begin
    nxt        = state;
    m_stall    = 1'b0;
    data_req   = 1'b0;
    latch_hold = 1'b0;
    wb_sel     = WB_BUBBLE;
    case (state)
      IDLE: begin
        if (e_valid && memop && !flush) begin
          latch_hold = 1'b1;
          m_stall    = 1'b1;
          nxt        = REQ;
        end else if (e_valid && !flush) begin
          wb_sel = WB_PASS;
        end
      end
      REQ: begin
        data_req = 1'b1;
        m_stall  = !(data_addr_ok && data_data_ok);
        if (data_addr_ok && data_data_ok) begin
          nxt = IDLE;
          if (!flush) wb_sel = WB_HOLD;
        end else if (data_addr_ok) begin
          nxt = flush ? DRAIN : WAIT;
        end else if (flush) begin
          nxt = IDLE;
        end
      end
      WAIT: begin
        m_stall = !data_data_ok;
        if (data_data_ok) begin
          nxt = IDLE;
          if (!flush) wb_sel = WB_HOLD;
        end else if (flush) begin
          nxt = DRAIN;
        end
      end
      DRAIN: begin
        m_stall = e_valid && memop;
        if (data_data_ok) nxt = IDLE;
        if (e_valid && !memop && !flush) wb_sel = WB_PASS;
      end
      default: nxt = IDLE;
    endcase
  end

  // park the memory instruction for the duration of its transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold      <= '0;
      hold_ctrl <= '0;
    end else if (latch_hold) begin
      hold.memread   <= e_memread;
      hold.memwrite  <= e_memwrite;
      hold.size      <= e_size;
      hold.sign      <= e_sign;
      hold.ex_out    <= e_ex_out;
      hold.wdata     <= e_wdata;
      hold.pcplus8   <= e_pcplus8;
      hold.reg_waddr <= e_reg_waddr;
      hold.cp0_rdata <= e_cp0_rdata;
      hold_ctrl      <= e_ctrl;
    end
  end

  // mem-to-wb register; bubbles are fully zeroed so w_ctrl is 0 when invalid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_valid     <= 1'b0;
      w_ex_out    <= '0;
      w_rdata_out <= '0;
      w_pcplus8   <= '0;
      w_reg_waddr <= '0;
      w_cp0_rdata <= '0;
      w_ctrl      <= '0;
    end else begin
      case (wb_sel)
        WB_PASS: begin
          w_valid     <= 1'b1;
          w_ex_out    <= e_ex_out;
          w_rdata_out <= '0;
          w_pcplus8   <= e_pcplus8;
          w_reg_waddr <= e_reg_waddr;
          w_cp0_rdata <= e_cp0_rdata;
          w_ctrl      <= e_ctrl;
        end
        WB_HOLD: begin
          w_valid     <= 1'b1;
          w_ex_out    <= hold.ex_out;
          w_rdata_out <= hold.memread ? ext_data : 32'h0;
          w_pcplus8   <= hold.pcplus8;
          w_reg_waddr <= hold.reg_waddr;
          w_cp0_rdata <= hold.cp0_rdata;
          w_ctrl      <= hold_ctrl;
        end
        default: begin
          w_valid     <= 1'b0;
          w_ex_out    <= '0;
          w_rdata_out <= '0;
          w_pcplus8   <= '0;
          w_reg_waddr <= '0;
          w_cp0_rdata <= '0;
          w_ctrl      <= '0;
        end
      endcase
    end
  end

endmodule
